// File: rtl/combine_tx_arbiter.sv
// combine_tx_arbiter
//
// Shares the single combined UDP/TCP/IP encoder between a UDP requester and a
// TCP requester. Requests are arbitrated round-robin in IDLE. The winner is
// granted and the encoder protocol select is driven, followed by one settle
// cycle and a one-cycle start pulse. The arbiter then waits for a fresh rising
// edge of the encoder fin and inserts GAP idle cycles before the next grant.
// The protocol select keeps its last value until the next selection, so the
// encoder mux never changes while it drains.
//
// Optional feature (macro ARB_TIMEOUT_EN): abort a packet after TIMEOUT cycles
// in WAIT_FIN without a fin rising edge. Without the macro, timeout is tied 0.
//
// Parameters:
//   CNT_W    width of the per-protocol completed-packet counters
//   GAP      idle cycles after each packet before the next grant (0 allowed)
//   TIMEOUT  WAIT_FIN abort limit in cycles (ARB_TIMEOUT_EN only)
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   req_udp      UDP requester wants to send one packet (level)
//   req_tcp      TCP requester wants to send one packet (level)
//   enc_fin      encoder completion; a rising edge marks packet end
//   gnt_udp      UDP owns the encoder
//   gnt_tcp      TCP owns the encoder
//   udp0_tcp1    protocol select to the encoder (0=UDP, 1=TCP)
//   start        one-cycle start pulse to the encoder
//   busy         high in every state except IDLE
//   done         one-cycle pulse, packet completed
//   timeout      one-cycle pulse, packet aborted
//   pkt_cnt_udp  completed UDP packets (wraps)
//   pkt_cnt_tcp  completed TCP packets (wraps)
// All outputs are registered.

module combine_tx_arbiter #(
    parameter int CNT_W   = 16,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_udp,
    input  logic             req_tcp,
    input  logic             enc_fin,
    output logic             gnt_udp,
    output logic             gnt_tcp,
    output logic             udp0_tcp1,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] pkt_cnt_udp,
    output logic [CNT_W-1:0] pkt_cnt_tcp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT_FIN,
        S_GAP
    } state_t;

    // The GAP down-counter runs GAP-1 .. 0, so it needs only clog2(GAP) bits.
    localparam int GAP_W = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
    localparam state_t POST_PKT = (GAP == 0) ? S_IDLE : S_GAP;

    // A zero abort limit has no meaning in either build.
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("combine_tx_arbiter: TIMEOUT must be at least 1");
    end

    state_t           state, state_nx;
    logic             last_sel, last_sel_nx;   // 1 = TCP was granted last
    logic             enc_fin_d;
    logic             fin_rise;
    logic             pick_tcp;
    logic             gnt_udp_nx, gnt_tcp_nx, sel_nx;
    logic             start_nx, busy_nx, done_nx;
    logic [CNT_W-1:0] cnt_udp_nx, cnt_tcp_nx;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] wait_cnt, wait_cnt_nx;
    logic            timeout_nx;
`else
    assign timeout = 1'b0;
`endif

    // enc_fin_d follows enc_fin in every state, so a level that is already
    // high when WAIT_FIN is entered never looks like a fresh edge.
    assign fin_rise = enc_fin & ~enc_fin_d;

    always_comb begin
        state_nx    = state;
        last_sel_nx = last_sel;
        gnt_udp_nx  = gnt_udp;
        gnt_tcp_nx  = gnt_tcp;
        sel_nx      = udp0_tcp1;
        start_nx    = 1'b0;
        done_nx     = 1'b0;
        cnt_udp_nx  = pkt_cnt_udp;
        cnt_tcp_nx  = pkt_cnt_tcp;
        gap_cnt_nx  = gap_cnt;
        pick_tcp    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        timeout_nx  = 1'b0;
        wait_cnt_nx = wait_cnt;
`endif

        case (state)
            S_IDLE: begin
                if (req_udp || req_tcp) begin
                    // Under contention the protocol not served last wins.
                    pick_tcp    = req_tcp & (~req_udp | ~last_sel);
                    state_nx    = S_SETUP;
                    gnt_udp_nx  = ~pick_tcp;
                    gnt_tcp_nx  = pick_tcp;
                    sel_nx      = pick_tcp;
                    last_sel_nx = pick_tcp;
                end
            end

            S_SETUP: begin
                state_nx = S_START;
                start_nx = 1'b1;
            end

            S_START: begin
                state_nx = S_WAIT_FIN;
`ifdef ARB_TIMEOUT_EN
                wait_cnt_nx = '0;
`endif
            end

            S_WAIT_FIN: begin
                if (fin_rise) begin
                    // Completion takes priority over a coincident expiry.
                    done_nx    = 1'b1;
                    gnt_udp_nx = 1'b0;
                    gnt_tcp_nx = 1'b0;
                    gap_cnt_nx = GAP_LOAD;
                    state_nx   = POST_PKT;
                    if (udp0_tcp1) begin
                        cnt_tcp_nx = pkt_cnt_tcp + CNT_W'(1);
                    end else begin
                        cnt_udp_nx = pkt_cnt_udp + CNT_W'(1);
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_cnt == TO_LAST) begin
                    timeout_nx = 1'b1;
                    gnt_udp_nx = 1'b0;
                    gnt_tcp_nx = 1'b0;
                    gap_cnt_nx = GAP_LOAD;
                    state_nx   = POST_PKT;
                end else begin
                    wait_cnt_nx = wait_cnt + TO_W'(1);
                end
`endif
            end

            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nx = S_IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt - GAP_W'(1);
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            last_sel    <= 1'b1;
            enc_fin_d   <= 1'b0;
            gnt_udp     <= 1'b0;
            gnt_tcp     <= 1'b0;
            udp0_tcp1   <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pkt_cnt_udp <= '0;
            pkt_cnt_tcp <= '0;
            gap_cnt     <= '0;
`ifdef ARB_TIMEOUT_EN
            timeout     <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            state       <= state_nx;
            last_sel    <= last_sel_nx;
            enc_fin_d   <= enc_fin;
            gnt_udp     <= gnt_udp_nx;
            gnt_tcp     <= gnt_tcp_nx;
            udp0_tcp1   <= sel_nx;
            start       <= start_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            pkt_cnt_udp <= cnt_udp_nx;
            pkt_cnt_tcp <= cnt_tcp_nx;
            gap_cnt     <= gap_cnt_nx;
`ifdef ARB_TIMEOUT_EN
            timeout     <= timeout_nx;
            wait_cnt    <= wait_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_combine_tx_arbiter.sv
// Testbench for combine_tx_arbiter. Two instances share one stimulus:
//   u_a  CNT_W=16, GAP=2, TIMEOUT=8
//   u_b  CNT_W=2,  GAP=0, TIMEOUT=8  (small counter to reach the wrap)
// Both are compared every cycle against a transaction-level model that tracks
// owner, cycles since grant and remaining gap cycles. Directed scenarios are
// followed by a randomized phase.

module tb_combine_tx_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset, req_udp, req_tcp, enc_fin;

    always #5 clk = ~clk;

    logic        a_gu, a_gt, a_sel, a_st, a_busy, a_done, a_to;
    logic [15:0] a_cu, a_ct;
    logic        b_gu, b_gt, b_sel, b_st, b_busy, b_done, b_to;
    logic [1:0]  b_cu, b_ct;

    combine_tx_arbiter #(.CNT_W(16), .GAP(2), .TIMEOUT(TO)) u_a (
        .clk(clk), .reset(reset), .req_udp(req_udp), .req_tcp(req_tcp),
        .enc_fin(enc_fin), .gnt_udp(a_gu), .gnt_tcp(a_gt), .udp0_tcp1(a_sel),
        .start(a_st), .busy(a_busy), .done(a_done), .timeout(a_to),
        .pkt_cnt_udp(a_cu), .pkt_cnt_tcp(a_ct)
    );

    combine_tx_arbiter #(.CNT_W(2), .GAP(0), .TIMEOUT(TO)) u_b (
        .clk(clk), .reset(reset), .req_udp(req_udp), .req_tcp(req_tcp),
        .enc_fin(enc_fin), .gnt_udp(b_gu), .gnt_tcp(b_gt), .udp0_tcp1(b_sel),
        .start(b_st), .busy(b_busy), .done(b_done), .timeout(b_to),
        .pkt_cnt_udp(b_cu), .pkt_cnt_tcp(b_ct)
    );

    logic [6:0] obs_a, obs_b;
    assign obs_a = {a_gu, a_gt, a_sel, a_st, a_busy, a_done, a_to};
    assign obs_b = {b_gu, b_gt, b_sel, b_st, b_busy, b_done, b_to};

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int cfg_gap [2] = '{2, 0};
    int cfg_mod [2] = '{65536, 4};

    bit m_act[2], m_tcp[2], m_last[2], m_sel[2], m_find[2];
    bit m_start[2], m_done[2], m_to[2];
    int m_age[2], m_gapl[2], m_cu[2], m_ct[2];
    bit m_rise;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] = 0; m_tcp[i] = 0; m_last[i] = 1; m_sel[i] = 0; m_find[i] = 0;
                m_start[i] = 0; m_done[i] = 0; m_to[i] = 0;
                m_age[i] = 0; m_gapl[i] = 0; m_cu[i] = 0; m_ct[i] = 0;
            end else begin
                m_rise = enc_fin && !m_find[i];
                m_start[i] = 0; m_done[i] = 0; m_to[i] = 0;
                if (m_act[i]) begin
                    // age before this edge: 0 setup, 1 start, >=2 waiting for fin
                    if (m_age[i] >= 2 && m_rise) begin
                        m_done[i] = 1;
                        if (m_tcp[i]) m_ct[i] = (m_ct[i] + 1) % cfg_mod[i];
                        else          m_cu[i] = (m_cu[i] + 1) % cfg_mod[i];
                        m_act[i]  = 0;
                        m_gapl[i] = cfg_gap[i];
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (m_age[i] - 1 == TO) begin
                        m_to[i]   = 1;
                        m_act[i]  = 0;
                        m_gapl[i] = cfg_gap[i];
                    end
`endif
                    else begin
                        if (m_age[i] == 0) m_start[i] = 1;
                        m_age[i]++;
                    end
                end else if (m_gapl[i] > 0) begin
                    m_gapl[i]--;
                end else if (req_udp || req_tcp) begin
                    m_tcp[i]  = req_tcp && !(req_udp && m_last[i]);
                    m_last[i] = m_tcp[i];
                    m_sel[i]  = m_tcp[i];
                    m_act[i]  = 1;
                    m_age[i]  = 0;
                end
                m_find[i] = enc_fin;
            end
        end
    end

    function automatic logic [6:0] exp_flags(input int i);
        return {m_act[i] && !m_tcp[i], m_act[i] && m_tcp[i], m_sel[i], m_start[i],
                m_act[i] || (m_gapl[i] > 0), m_done[i], m_to[i]};
    endfunction

    task automatic compare_all();
        check("flags_a",   32'(obs_a), 32'(exp_flags(0)));
        check("cnt_udp_a", 32'(a_cu),  32'(m_cu[0]));
        check("cnt_tcp_a", 32'(a_ct),  32'(m_ct[0]));
        check("flags_b",   32'(obs_b), 32'(exp_flags(1)));
        check("cnt_udp_b", 32'(b_cu),  32'(m_cu[1]));
        check("cnt_tcp_b", 32'(b_ct),  32'(m_ct[1]));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Pulses enc_fin periodically so any packet in flight drains.
    task automatic wait_idle();
        int k;
        k = 0;
        while ((a_busy || b_busy) && k < 80) begin
            enc_fin = ((k % 4) == 1);
            step();
            k++;
        end
        enc_fin = 0;
        step();
        check("idle_wait", 32'(a_busy | b_busy), 32'(0));
    endtask

    task automatic wait_start_a();
        int k;
        k = 0;
        while (!a_st && k < 50) begin step(); k++; end
        check("start_wait_a", 32'(a_st), 32'(1));
    endtask

    task automatic wait_start_b();
        int k;
        k = 0;
        while (!b_st && k < 50) begin step(); k++; end
        check("start_wait_b", 32'(b_st), 32'(1));
    endtask

    initial begin
        int order[4];
        int dn, k, to_cnt, to_at;

        reset = 1; req_udp = 0; req_tcp = 0; enc_fin = 0;
        @(negedge clk);
        step();
        check("rst_flags_a", 32'(obs_a), 32'(0));
        check("rst_cnt_a",   32'({a_cu, a_ct}), 32'(0));
        reset = 0;
        step();

        // 1: single UDP request
        req_udp = 1; step();
        check("t1_gnt_udp", 32'(a_gu), 32'(1));
        check("t1_sel",     32'(a_sel), 32'(0));
        check("t1_no_start_yet", 32'(a_st), 32'(0));
        req_udp = 0; step();
        check("t1_start", 32'(a_st), 32'(1));
        step();
        check("t1_start_once", 32'(a_st), 32'(0));
        steps(17);
        enc_fin = 1; step();
        check("t1_done",     32'(a_done), 32'(1));
        check("t1_cnt_udp",  32'(a_cu), 32'(1));
        check("t1_gnt_drop", 32'(a_gu), 32'(0));
        enc_fin = 0; step();
        check("t1_done_once", 32'(a_done), 32'(0));

        // 2: contention, four packets
        wait_idle();
        reset = 1; step(); reset = 0;
        req_udp = 1; req_tcp = 1;
        for (int p = 0; p < 4; p++) begin
            wait_start_a();
            order[p] = a_gt ? 1 : 0;
            if (p == 3) begin req_udp = 0; req_tcp = 0; end
            steps(2);
            enc_fin = 1; step();
            check("t2_done", 32'(a_done), 32'(1));
            enc_fin = 0;
        end
        for (int p = 0; p < 4; p++) check("t2_order", 32'(order[p]), 32'(p % 2));
        check("t2_cnt_udp", 32'(a_cu), 32'(2));
        check("t2_cnt_tcp", 32'(a_ct), 32'(2));

        // 3: enc_fin already high entering WAIT_FIN
        wait_idle();
        req_udp = 1; enc_fin = 1; step();
        req_udp = 0; dn = 0;
        for (int j = 0; j < 6; j++) begin step(); dn += a_done; end
        enc_fin = 0;
        for (int j = 0; j < 3; j++) begin step(); dn += a_done; end
        enc_fin = 1; step(); dn += a_done;
        check("t3_done_second_rise", 32'(a_done), 32'(1));
        enc_fin = 0; step(); dn += a_done;
        check("t3_done_count", 32'(dn), 32'(1));

        // 4: reset in WAIT_FIN with TCP granted
        wait_idle();
        req_tcp = 1; step(); req_tcp = 0;
        steps(3);
        check("t4_gnt_tcp", 32'(a_gt), 32'(1));
        reset = 1; step();
        check("t4_rst_flags", 32'(obs_a), 32'(0));
        check("t4_rst_cnt",   32'({a_cu, a_ct}), 32'(0));
        reset = 0; req_udp = 1; req_tcp = 1; step();
        check("t4_udp_first", 32'(a_gu), 32'(1));
        req_udp = 0; req_tcp = 0;
        steps(3);
        enc_fin = 1; step(); enc_fin = 0;

        // 5: GAP=0 back-to-back TCP and counter wrap on u_b
        wait_idle();
        reset = 1; step(); reset = 0;
        req_tcp = 1;
        for (int p = 0; p < 4; p++) begin
            wait_start_b();
            if (p == 3) req_tcp = 0;
            steps(2);
            enc_fin = 1; step();
            check("t5_done_b", 32'(b_done), 32'(1));
            check("t5_cnt_b",  32'(b_ct), 32'((p + 1) % 4));
            enc_fin = 0;
            if (p < 3) begin
                k = 0;
                while (!b_st && k < 20) begin step(); k++; end
                check("t5_done_to_start", 32'(k), 32'(2));
            end
        end

        // 6: no fin at all
        wait_idle();
        reset = 1; step(); reset = 0;
        req_udp = 1; step(); req_udp = 0;
        to_cnt = 0; to_at = -1;
        for (int j = 2; j <= 15; j++) begin
            step();
            if (a_to) begin to_cnt++; to_at = j; end
        end
`ifdef ARB_TIMEOUT_EN
        check("t6_timeout_count", 32'(to_cnt), 32'(1));
        check("t6_timeout_cycle", 32'(to_at), 32'(11));
        check("t6_busy", 32'(a_busy), 32'(0));
`else
        check("t6_timeout_count", 32'(to_cnt), 32'(0));
        check("t6_timeout_cycle", 32'(to_at), 32'(-1));
        check("t6_busy", 32'(a_busy), 32'(1));
`endif
        check("t6_cnt_unchanged", 32'(a_cu), 32'(0));
        enc_fin = 1; step(); enc_fin = 0; step();

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            reset   = ($urandom_range(0, 299) == 0);
            req_udp = ($urandom_range(0, 2) == 0);
            req_tcp = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) enc_fin = ~enc_fin;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
